mult_fu: RTL
============

MULT_FU -- requirements
Module: mult_fu

Interface
REQ-001 Parameter BITS_PER_CYCLE, default 2: multiplier bits retired per iteration; must be 1, 2, 4 or 8; K = 32/BITS_PER_CYCLE.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-high.
REQ-004 start  input  1  issue request from the issue arbiter for this unit.
REQ-005 input_data  input  issue_fu_data_t  operands rs1_v/rs2_v (32b each), funct3, pd (phys_reg), rob_idx.
REQ-006 flush  input  1  pipeline flush (mispredict); kills in-flight op.
REQ-007 busy  output  1  unit occupied; feeds the arbiter's mult_busy bit.
REQ-008 cdb_valid  output  1  result ready for broadcast.
REQ-009 cdb_ready  input  1  CDB grant for this unit.
REQ-010 cdb_value  output  32  result.
REQ-011 cdb_pd  output  phys_reg  destination physical register.
REQ-012 cdb_rob_idx  output  rob_idx_t  ROB tag.

Function
REQ-013 FSM states IDLE, CALC, FIXUP, DONE held in a registered state_q.
REQ-014 busy SHALL equal (state_q != IDLE), driven from registers only.
REQ-015 IDLE: start=1 and flush=0 -> capture input_data, magnitudes and result sign, clear accumulator and counter, go CALC; otherwise stay.
REQ-016 CALC: each cycle add BITS_PER_CYCLE partial products to the 64b unsigned accumulator, increment counter; after exactly K CALC cycles go FIXUP.
REQ-017 FIXUP: conditionally two's-complement negate the 64b product, select the half per funct3, register it into cdb_value, go DONE.
REQ-018 funct3 000 MUL = low 32 of signed x signed; 001 MULH = high 32 of signed x signed; 010 MULHSU = high 32 of signed rs1 x unsigned rs2; 011 MULHU = high 32 of unsigned x unsigned; other encodings are treated as MUL.
REQ-019 Operand magnitude of 0x80000000 signed SHALL be 2^31, held as 33b or unsigned 32b, with no overflow.
REQ-020 Latency: start sampled in cycle 0; cycles 1..K CALC; cycle K+1 FIXUP; cdb_valid first high in cycle K+2 (18 at default).
REQ-021 DONE: cdb_valid=1; cdb_value, cdb_pd and cdb_rob_idx are stable until granted; on cdb_ready=1 go IDLE next edge.
REQ-022 cdb_valid SHALL be 0 in every state except DONE.
REQ-023 start while busy=1 SHALL be ignored, state unaffected; the bench asserts it never occurs.
REQ-024 flush=1 in any state -> IDLE next edge; no cdb_valid for the killed op; flush overrides cdb_ready and start in the same cycle.
REQ-025 No back-to-back overlap: the next start is accepted only once busy=0, i.e. the cycle after the grant edge.

Reset
REQ-026 rst asynchronously forces state_q=IDLE, busy=0, cdb_valid=0, cdb_value=0, cdb_pd=0, cdb_rob_idx=0, counter=0, accumulator=0.
REQ-027 Reset mid-operation discards the op silently; the first start after rst deassertion behaves per REQ-015.

Structure
REQ-028 rv32i_types package holds issue_fu_data_t, phys_reg, rob_idx_t, the mult funct3 encodings as an enum, and mult_fu_state_t.
REQ-029 Single module, no sub-modules: FSM, counter ($clog2(K)+1 bits), operand/sign registers and accumulator in one file.
REQ-030 One instance per mult unit; start and busy connect to one bit of the arbiter's mult_start/mult_busy vectors.

Verification
REQ-031 MUL 7 x 0xFFFFFFFD, pd=5, rob=3, cdb_ready=1 -> cdb_valid in cycle 18 only, value 0xFFFFFFEB, pd 5, rob 3; busy low cycle 19.
REQ-032 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MUL 0x80000000 x 0xFFFFFFFF -> 0x80000000.
REQ-033 cdb_ready held 0 for 5 cycles in DONE -> cdb_valid, value and tags stable, busy=1; grant -> IDLE; new start the next cycle completes after 18 more cycles.
REQ-034 flush in CALC cycle 5 -> busy=0 next cycle, no cdb_valid ever; start+flush in the same cycle -> op dropped, busy stays 0.
REQ-035 rst pulsed asynchronously mid-CALC -> all outputs 0 immediately, without waiting for a clock edge; subsequent MUL 3 x 4 -> 12 at cycle 18.
REQ-036 Randomized 10k ops, all funct3 values, all four BITS_PER_CYCLE values, random cdb_ready stalls -> every result matches a 64b reference model, with latency per REQ-020.

Source files
------------

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Package  : rv32i_types
// Purpose  : Shared types for the issue/execute path: physical register and
//            ROB tags, issue payload, multiply funct3 encodings and the
//            multiply unit state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_types;

    localparam int PHYS_REG_W = 6;
    localparam int ROB_IDX_W  = 4;

    typedef logic [PHYS_REG_W-1:0] phys_reg;
    typedef logic [ROB_IDX_W-1:0]  rob_idx_t;

    // M-extension multiply flavours; unlisted encodings behave as MUL
    typedef enum logic [2:0] {
        MULT_MUL    = 3'b000,
        MULT_MULH   = 3'b001,
        MULT_MULHSU = 3'b010,
        MULT_MULHU  = 3'b011
    } mult_funct3_t;

    // Issue payload delivered to a functional unit
    typedef struct packed {
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [2:0]  funct3;
        phys_reg     pd;
        rob_idx_t    rob_idx;
    } issue_fu_data_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } mult_fu_state_t;

endpackage : rv32i_types
`default_nettype wire

// File: rtl/mult_fu.sv
`default_nettype none
// ============================================================================
// Module   : mult_fu
// Purpose  : Iterative 32x32 multiplier for the RV32M MUL/MULH/MULHSU/MULHU
//            ops. Works on operand magnitudes, retires BITS_PER_CYCLE
//            multiplier bits per cycle into a 64b accumulator, then applies
//            the result sign and selects the requested half for the CDB.
// Revision : 1.0 - initial release
// ============================================================================
module mult_fu
    import rv32i_types::*;
#(
    parameter int BITS_PER_CYCLE = 2   // 1, 2, 4 or 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  issue_fu_data_t input_data,
    input  logic           flush,
    output logic           busy,
    output logic           cdb_valid,
    input  logic           cdb_ready,
    output logic [31:0]    cdb_value,
    output phys_reg        cdb_pd,
    output rob_idx_t       cdb_rob_idx
);

    localparam int K     = 32 / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(K) + 1;

    mult_fu_state_t    state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [63:0]       mcand_q;     // multiplicand magnitude, pre-shifted to the current bit weight
    logic [31:0]       mplier_q;    // multiplier magnitude, consumed from the LSB end
    logic [63:0]       acc_q;       // unsigned magnitude product
    logic              neg_q;       // final product must be negated
    logic [2:0]        funct3_q;

    logic              signed_a;
    logic              signed_b;
    logic              neg_a;
    logic              neg_b;
    logic [31:0]       mag_a;
    logic [31:0]       mag_b;
    logic [63:0]       step_sum;
    logic [63:0]       product;
    logic [31:0]       result;
    logic              last_calc;

    // Operand sign handling; the magnitude of 0x80000000 is 2^31, which
    // fits in 32 unsigned bits so no widening is needed.
    always_comb begin
        signed_a = (input_data.funct3 != MULT_MULHU);
        signed_b = (input_data.funct3 != MULT_MULHU) && (input_data.funct3 != MULT_MULHSU);
        neg_a    = signed_a & input_data.rs1_v[31];
        neg_b    = signed_b & input_data.rs2_v[31];
        mag_a    = neg_a ? (~input_data.rs1_v + 32'd1) : input_data.rs1_v;
        mag_b    = neg_b ? (~input_data.rs2_v + 32'd1) : input_data.rs2_v;
    end

    // Sum of the BITS_PER_CYCLE partial products retired this iteration
    always_comb begin
        step_sum = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier_q[j]) begin
                step_sum = step_sum + (mcand_q << j);
            end
        end
    end

    // Sign fix-up and half selection
    always_comb begin
        product = neg_q ? (~acc_q + 64'd1) : acc_q;
        case (funct3_q)
            MULT_MULH, MULT_MULHSU, MULT_MULHU: result = product[63:32];
            default:                           result = product[31:0];
        endcase
    end

    assign last_calc = (cnt_q == CNT_W'(K - 1));
    assign busy      = (state_q != ST_IDLE);
    assign cdb_valid = (state_q == ST_DONE);

    // Control FSM and datapath registers; flush kills any op and wins over
    // start and cdb_ready in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            funct3_q    <= '0;
            cdb_value   <= '0;
            cdb_pd      <= '0;
            cdb_rob_idx <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mcand_q     <= {32'd0, mag_a};
                        mplier_q    <= mag_b;
                        neg_q       <= neg_a ^ neg_b;
                        funct3_q    <= input_data.funct3;
                        cdb_pd      <= input_data.pd;
                        cdb_rob_idx <= input_data.rob_idx;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        state_q     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q    <= acc_q + step_sum;
                    mcand_q  <= mcand_q << BITS_PER_CYCLE;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_calc) begin
                        state_q <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    cdb_value <= result;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    if (cdb_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule : mult_fu
`default_nettype wire
